gauss_win3x3_sum: RTL and testbench

- Streaming 3x3 Gaussian-kernel weighted-sum stage.
- Consumes raster-order 8-bit pixels and keeps two rows of history in line buffers.
- Emits the unnormalised kernel sum (weights 1 2 1 / 2 4 2 / 1 2 1, total 16) for every interior pixel.
- Sits directly upstream of the divide-by-16 normaliser: sum_out is 15 bits so it feeds the divider's dividend input unchanged.

---
 rtl/gauss_pkg.sv | 23 ++
 rtl/gauss_line_buffer.sv | 28 ++
 rtl/gauss_win3x3_sum.sv | 163 ++++++++++++++++
 tb/tb_gauss_win3x3_sum.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// Shared constants and state encoding for the 3x3 Gaussian stage and its divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gauss_pkg;

    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;
    localparam int DEF_PIX_W = 8;
    localparam int DEF_SUM_W = 15;

    // Kernel weights; K_NORM is the divisor the downstream normaliser applies.
    localparam int unsigned K_CORNER = 1;
    localparam int unsigned K_EDGE   = 2;
    localparam int unsigned K_CENTRE = 4;
    localparam int unsigned K_NORM   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gauss_line_buffer.sv
// One-row pixel delay line addressed by column; read-before-write at the same address.
// Latency: read is combinational, write lands on the next rising edge.
// Backpressure: none; writes whenever wr_en is high.
module gauss_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_dat,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Old contents are read out combinationally before the write replaces them.
    assign rd_dat = mem[addr];

    // Contents carry no meaning across reset, so the array is left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_dat;
        end
    end

endmodule

// File: rtl/gauss_win3x3_sum.sv
// Streaming 3x3 Gaussian (1 2 1 / 2 4 2 / 1 2 1) unnormalised sum over interior pixels.
// Latency: fixed 3 cycles from the completing pixel's accept to sum_valid.
// Backpressure: none; every pix_valid cycle is consumed, idle cycles freeze the window.
module gauss_win3x3_sum
    import gauss_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W,
    parameter int SUM_W = DEF_SUM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             pix_sof,
    output logic [SUM_W-1:0] sum_out,
    output logic             sum_valid,
    output logic             sum_eol,
    output logic             sum_eof
);

    localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int RSW = PIX_W + 3;   // one weighted row, worst case 8*(2^PIX_W-1)
    localparam int SW  = PIX_W + 4;   // full kernel, worst case 16*(2^PIX_W-1)

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, cur_col;
    logic [RW-1:0]   row_q, cur_row;
    logic            accept, row_end, last_pix, res_hit;

    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    logic [PIX_W-1:0] win [3][3];   // [row: top..bottom][col: oldest..newest]

    logic            s1_vld, s1_eol, s1_eof;
    logic            s2_vld, s2_eol, s2_eof;
    logic [RSW-1:0]  sum_top, sum_mid, sum_bot;
    logic [SW-1:0]   total;

    // A sof pixel is always position (0,0) regardless of where the counters were.
    assign accept   = pix_valid && (pix_sof || (state_q == RUN));
    assign cur_col  = pix_sof ? '0 : col_q;
    assign cur_row  = pix_sof ? '0 : row_q;
    assign row_end  = (cur_col == CW'(IMG_W - 1));
    assign last_pix = row_end && (cur_row == RW'(IMG_H - 1));
    // Requiring col>=2 keeps the window inside one row; row>=2 keeps stale lines out.
    assign res_hit  = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: sof restarts from anywhere, the final pixel closes the frame.
    always_comb begin
        state_d = state_q;
        if (pix_valid && pix_sof) begin
            state_d = RUN;
        end
        if (accept && last_pix) begin
            state_d = DONE;
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (row_end) begin
                col_q <= '0;
                row_q <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
            end else begin
                col_q <= cur_col + CW'(1);
                row_q <= cur_row;
            end
        end
    end

    // LB0 carries row r-1, LB1 carries row r-2 (fed from LB0's outgoing value).
    gauss_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk    (clk),
        .wr_en  (accept),
        .addr   (cur_col),
        .wr_dat (pix_in),
        .rd_dat (lb0_rd)
    );

    gauss_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk    (clk),
        .wr_en  (accept),
        .addr   (cur_col),
        .wr_dat (lb0_rd),
        .rd_dat (lb1_rd)
    );

    // Window shifts one column per accepted pixel; new column enters on the right.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1_rd;
            win[1][2] <= lb0_rd;
            win[2][2] <= pix_in;
        end
    end

    // Valid/flag tags travel alongside the data; these are the only pipeline state reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_eol <= 1'b0;
            s1_eof <= 1'b0;
            s2_vld <= 1'b0;
            s2_eol <= 1'b0;
            s2_eof <= 1'b0;
        end else begin
            s1_vld <= res_hit;
            s1_eol <= row_end;
            s1_eof <= last_pix;
            s2_vld <= s1_vld;
            s2_eol <= s1_eol;
            s2_eof <= s1_eof;
        end
    end

    // Weighted row sums, captured only when the window holds a complete result.
    always_ff @(posedge clk) begin
        if (s1_vld) begin
            sum_top <= RSW'(K_CORNER * win[0][0] + K_EDGE   * win[0][1] + K_CORNER * win[0][2]);
            sum_mid <= RSW'(K_EDGE   * win[1][0] + K_CENTRE * win[1][1] + K_EDGE   * win[1][2]);
            sum_bot <= RSW'(K_CORNER * win[2][0] + K_EDGE   * win[2][1] + K_CORNER * win[2][2]);
        end
    end

    assign total = SW'(sum_top) + SW'(sum_mid) + SW'(sum_bot);

    // Registered outputs; sum_out holds between results, flags are single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_out   <= '0;
            sum_valid <= 1'b0;
            sum_eol   <= 1'b0;
            sum_eof   <= 1'b0;
        end else begin
            sum_valid <= s2_vld;
            sum_eol   <= s2_vld && s2_eol;
            sum_eof   <= s2_vld && s2_eof;
            if (s2_vld) begin
                sum_out <= SUM_W'(total);
            end
        end
    end

endmodule

// File: tb/tb_gauss_win3x3_sum.sv
// Self-checking bench for gauss_win3x3_sum on a 5x4 frame.
// Latency: results expected 3 cycles after the completing pixel.
// Backpressure: none; stimulus drives pix_valid freely.
module tb_gauss_win3x3_sum;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int PW = 8;
    localparam int SW = 15;

    logic          clk;
    logic          rst_n;
    logic [PW-1:0] pix_in;
    logic          pix_valid;
    logic          pix_sof;
    logic [SW-1:0] sum_out;
    logic          sum_valid;
    logic          sum_eol;
    logic          sum_eof;

    gauss_win3x3_sum #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .SUM_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .sum_out   (sum_out),
        .sum_valid (sum_valid),
        .sum_eol   (sum_eol),
        .sum_eof   (sum_eof)
    );

    typedef struct {
        int sum;
        bit eol;
        bit eof;
        int due;
    } exp_t;

    exp_t sb[$];
    int   obs[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   eols = 0;
    int   eofs = 0;
    int   last_sum = 0;

    // Reference frame model: current frame image and raster position.
    int   img [H][W];
    bit   m_run = 0;
    int   mr = 0;
    int   mc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model_sum(input int r, input int c);
        int s;
        s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += img[r-2+i][c-2+j] * ((i == 1) ? 2 : 1) * ((j == 1) ? 2 : 1);
        return s;
    endfunction

    function automatic int pix_val(input int mode, input int val, input int r, input int c);
        if (mode == 0) return val;
        if (mode == 1) return (r == 1 && c == 1) ? val : 0;
        return int'($urandom_range(0, 255));
    endfunction

    // Scoreboard consumer: every pulse must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (sum_valid) begin
                pulses++;
                if (sum_eol) eols++;
                if (sum_eof) eofs++;
                obs.push_back(int'(sum_out));
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse sum_out=%0d at cycle %0d, no result expected", sum_out, cyc);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (sum_out !== SW'(e.sum)) begin
                        errors++;
                        $display("FAIL sum_value got %0d expected %0d", sum_out, e.sum);
                    end
                    checks++;
                    if (sum_eol !== e.eol || sum_eof !== e.eof) begin
                        errors++;
                        $display("FAIL flags got eol=%0b eof=%0b expected eol=%0b eof=%0b",
                                 sum_eol, sum_eof, e.eol, e.eof);
                    end
                    checks++;
                    if (cyc != e.due) begin
                        errors++;
                        $display("FAIL latency got cycle %0d expected cycle %0d", cyc, e.due);
                    end
                end
                last_sum = int'(sum_out);
            end else begin
                checks++;
                if (sum_out !== SW'(last_sum) || sum_eol !== 1'b0 || sum_eof !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_hold got sum=%0d eol=%0b eof=%0b expected sum=%0d eol=0 eof=0",
                             sum_out, sum_eol, sum_eof, last_sum);
                end
            end
        end
    end

    task automatic send_pix(input int v, input bit sof);
        int   r;
        int   c;
        exp_t e;
        pix_in    = PW'(v);
        pix_valid = 1'b1;
        pix_sof   = sof;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        if (sof || m_run) begin
            r = sof ? 0 : mr;
            c = sof ? 0 : mc;
            m_run = 1'b1;
            img[r][c] = v;
            if (r >= 2 && c >= 2) begin
                e.sum = model_sum(r, c);
                e.eol = (c == W - 1);
                e.eof = (c == W - 1) && (r == H - 1);
                e.due = cyc + 2;
                sb.push_back(e);
            end
            if (c == W - 1) begin
                mc = 0;
                if (r == H - 1) begin
                    mr = 0;
                    m_run = 1'b0;
                end else begin
                    mr = r + 1;
                end
            end else begin
                mc = c + 1;
                mr = r;
            end
        end
    endtask

    task automatic idle(input int n, input bit sof_noise);
        pix_valid = 1'b0;
        pix_sof   = sof_noise;
        repeat (n) @(posedge clk);
        #1;
        pix_sof = 1'b0;
    endtask

    task automatic send_pixels(input int mode, input int val, input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            send_pix(pix_val(mode, val, k / W, k % W), k == 0);
            if (gaps) idle(int'($urandom_range(1, 3)), (k % 4) == 1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        int p0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sum_out !== '0 || sum_valid !== 1'b0 || sum_eol !== 1'b0 || sum_eof !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got sum=%0d vld=%0b eol=%0b eof=%0b expected all 0",
                     sum_out, sum_valid, sum_eol, sum_eof);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        p0 = pulses;
        for (int k = 0; k < 15; k++) send_pix(50, 1'b0);
        idle(6, 1'b0);
        checks++;
        if (pulses != p0) begin
            errors++;
            $display("FAIL idle_no_sof got %0d pulses expected 0", pulses - p0);
        end
    endtask

    task automatic test_constant();
        int p0, e0, f0;
        obs.delete();
        p0 = pulses; e0 = eols; f0 = eofs;
        send_pixels(0, 255, W * H, 1'b0);
        drain();
        checks++;
        if (pulses - p0 != 6 || eols - e0 != 2 || eofs - f0 != 1) begin
            errors++;
            $display("FAIL const_counts got pulses=%0d eol=%0d eof=%0d expected 6 2 1",
                     pulses - p0, eols - e0, eofs - f0);
        end
        for (int i = 0; i < obs.size(); i++) begin
            checks++;
            if (obs[i] != 4080) begin
                errors++;
                $display("FAIL const_sum[%0d] got %0d expected 4080", i, obs[i]);
            end
        end
    endtask

    task automatic test_impulse(input bit gaps);
        int imp [6];
        imp = '{400, 200, 0, 200, 100, 0};
        obs.delete();
        send_pixels(1, 100, W * H, gaps);
        drain();
        checks++;
        if (obs.size() != 6) begin
            errors++;
            $display("FAIL impulse_count gaps=%0b got %0d expected 6", gaps, obs.size());
        end
        for (int i = 0; i < 6 && i < obs.size(); i++) begin
            checks++;
            if (obs[i] != imp[i]) begin
                errors++;
                $display("FAIL impulse_sum[%0d] gaps=%0b got %0d expected %0d", i, gaps, obs[i], imp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int imp [6];
        imp = '{400, 200, 0, 200, 100, 0};
        obs.delete();
        send_pixels(1, 100, W * H, 1'b0);
        send_pixels(0, 16, W * H, 1'b0);
        drain();
        checks++;
        if (obs.size() != 12) begin
            errors++;
            $display("FAIL b2b_count got %0d expected 12", obs.size());
        end
        for (int i = 0; i < 12 && i < obs.size(); i++) begin
            checks++;
            if (obs[i] != ((i < 6) ? imp[i] : 256)) begin
                errors++;
                $display("FAIL b2b_sum[%0d] got %0d expected %0d", i, obs[i], (i < 6) ? imp[i] : 256);
            end
        end
        for (int k = 0; k < 3; k++) send_pix(200, 1'b0);
        obs.delete();
        send_pixels(0, 16, W * H, 1'b0);
        drain();
        checks++;
        if (obs.size() != 6) begin
            errors++;
            $display("FAIL junk_drop_count got %0d expected 6", obs.size());
        end
        for (int i = 0; i < obs.size(); i++) begin
            checks++;
            if (obs[i] != 256) begin
                errors++;
                $display("FAIL junk_drop_sum[%0d] got %0d expected 256", i, obs[i]);
            end
        end
    endtask

    task automatic test_sof_restart();
        int f0;
        obs.delete();
        f0 = eofs;
        send_pixels(2, 0, 2 * W + 3, 1'b0);
        send_pixels(2, 0, W * H, 1'b0);
        drain();
        checks++;
        if (obs.size() != 7 || eofs - f0 != 1) begin
            errors++;
            $display("FAIL sof_restart got pulses=%0d eof=%0d expected 7 1", obs.size(), eofs - f0);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        send_pixels(2, 0, 3 * W + 1, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (sum_out !== '0 || sum_valid !== 1'b0 || sum_eol !== 1'b0 || sum_eof !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got sum=%0d vld=%0b expected 0 0", sum_out, sum_valid);
        end
        sb.delete();
        last_sum = 0;
        m_run = 1'b0;
        mr = 0;
        mc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        p0 = pulses;
        for (int k = 0; k < 4; k++) send_pix(77, 1'b0);
        idle(6, 1'b0);
        checks++;
        if (pulses != p0) begin
            errors++;
            $display("FAIL post_reset_quiet got %0d pulses expected 0", pulses - p0);
        end
        obs.delete();
        send_pixels(2, 0, W * H, 1'b1);
        drain();
        checks++;
        if (obs.size() != 6) begin
            errors++;
            $display("FAIL post_reset_frame got %0d results expected 6", obs.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_in    = '0;
        test_reset();
        test_constant();
        test_impulse(1'b0);
        test_impulse(1'b1);
        test_back_to_back();
        test_sof_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
